voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
Polyphonic note scheduler in front of a bank of NUM_VOICES mono voice datapaths (frequency_getter, envelope, wave generator per voice).
- Accepts note-on/note-off events from the keyboard decoder over a valid/ready handshake.
- Assigns each event to a voice, stealing the oldest voice when none is free.
- Drives each voice's note_in pulse, note, octave and gate.
- Tracks voice lifetime until the voice's envelope reports release complete.

Parameters:
NUM_VOICES, 4, number of voice datapaths managed (2..8)
AGE_W, 8, width of per-voice saturating age counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ev_valid  in  1  event present
ev_ready  out  1  allocator can accept an event
ev_on  in  1  1 = note-on, 0 = note-off
ev_note  in  4  note index 0..11
ev_octave  in  3  octave 0..7
voice_rel_done  in  NUM_VOICES  per-voice one-cycle pulse: release phase finished
voice_note_in  out  NUM_VOICES  per-voice one-cycle load/retrigger pulse
voice_gate  out  NUM_VOICES  1 while key held (envelope A/D/S), 0 = release
voice_note  out  4*NUM_VOICES  packed note per voice, voice 0 in LSBs
voice_octave  out  3*NUM_VOICES  packed octave per voice
active_count  out  4  number of voices not FREE

Behaviour:
- Reset (asynchronous): all voices FREE; gate, note_in, note, octave, age, active_count = 0; FSM IDLE; ev_ready = 1. Any in-flight event is discarded.
- Top FSM:
  - IDLE: ev_ready = 1; on ev_valid && ev_ready, latch the event and go to SEARCH.
  - SEARCH: ev_ready = 0; register the selection result; go to ASSIGN.
  - ASSIGN: ev_ready = 0; update the selected voice; go to IDLE.
  - Throughput is 1 event per 3 cycles. An event accepted at cycle T produces its voice_note_in pulse at T+2, and outputs are updated at T+3.
- Voice states: FREE, HELD, RELEASING. voice_gate = 1 only in HELD.
- Note-on selection, first rule that matches wins:
  1. A voice (HELD or RELEASING) with identical note/octave: retrigger it.
  2. The lowest-index FREE voice.
  3. The RELEASING voice with the largest age.
  4. The HELD voice with the largest age (steal).
  - Ties go to the lowest index.
  - The selected voice goes to HELD, latches note/octave, age = 0, and gets a note_in pulse.
  - Every other non-FREE voice increments its age, saturating at 2^AGE_W-1.
- Note-off: the matching HELD voice goes to RELEASING (gate falls in ASSIGN). No note_in pulse, ages unchanged. No match: event consumed silently.
- ev_note > 11: event accepted and dropped; no state change.
- voice_rel_done: a RELEASING voice goes to FREE on the next edge; ignored in FREE or HELD.
- rel_done and ASSIGN targeting the same voice in the same cycle: ASSIGN wins; the voice ends HELD.
- active_count is registered and reflects voice states after each edge.

Optional Feature:
SUSTAIN_PEDAL_EN
- When defined, adds input sustain_pedal (1 bit) and a voice state SUSTAINED.
  - A note-off while the pedal is high moves a HELD voice to SUSTAINED; gate stays 1.
  - A pedal falling edge moves all SUSTAINED voices to RELEASING in one cycle.
  - SUSTAINED voices are eligible for retrigger (rule 1) and are stolen before HELD voices.
- When undefined, there is no port and no extra state; behaviour is exactly as above.

Decomposition:
- Package synth_pkg holds:
  - voice state enum (FREE, HELD, RELEASING, SUSTAINED);
  - NOTE_W = 4, OCT_W = 3, MAX_NOTE = 11;
  - the event struct {on, note, octave}.
- Sub-module voice_select: purely combinational priority picker. Inputs are the voice states, notes, octaves, ages and the latched event; outputs are the selected index and a hit/valid flag. The top level holds the FSM and the per-voice registers.

Test Plan:
- Reset, then note-on C4 (note 0, octave 4) → ev_ready low for 2 cycles; voice 0 note_in pulse at T+2; gate[0] = 1; active_count = 1.
- Four note-ons 0,2,4,5 (oct 4), then note-on 7 → voice 0 stolen (oldest HELD); voice_note[3:0] = 7; active_count = 4.
- Note-on 9 then note-off 9 → gate falls and the voice is RELEASING. rel_done pulse → voice FREE, active_count decrements. A second note-off 9 → no change.
- Note-on 4/oct 3 while the same voice is RELEASING → same index retriggered, gate = 1, no new voice used.
- rel_done and ASSIGN on the same voice in the same cycle → voice HELD; ev_note = 13 → accepted, no pulse, no state change.
- Assert reset mid-SEARCH → all outputs 0 immediately, ev_ready = 1 after release.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and constants for the polyphonic voice allocator.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional feature macro: SUSTAIN_PEDAL_EN (adds SUSTAINED usage).
package synth_pkg;
    localparam int NOTE_W = 4;
    localparam int OCT_W  = 3;
    localparam logic [NOTE_W-1:0] MAX_NOTE = 4'd11;

    // Per-voice lifetime state; SUSTAINED is only reachable with the pedal build
    typedef enum logic [1:0] {
        V_FREE      = 2'd0,
        V_HELD      = 2'd1,
        V_RELEASING = 2'd2,
        V_SUSTAINED = 2'd3
    } voice_state_e;

    // Top-level event pipeline: accept, select, commit
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_ASSIGN = 2'd2
    } fsm_state_e;

    typedef struct packed {
        logic              on;
        logic [NOTE_W-1:0] note;
        logic [OCT_W-1:0]  octave;
    } event_t;
endpackage

// File: rtl/voice_select.sv
// Combinational priority picker choosing which voice a latched event targets.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; sel_vld_o = 0 means the event changes nothing. Macro: SUSTAIN_PEDAL_EN.
module voice_select
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8,
    localparam int IDX_W     = $clog2(NUM_VOICES)
) (
    input  voice_state_e [NUM_VOICES-1:0]             state_i,
    input  logic         [NUM_VOICES-1:0][NOTE_W-1:0] note_i,
    input  logic         [NUM_VOICES-1:0][OCT_W-1:0]  oct_i,
    input  logic         [NUM_VOICES-1:0][AGE_W-1:0]  age_i,
    input  event_t                                    ev_i,
    output logic         [IDX_W-1:0]                  sel_idx_o,
    output logic                                      sel_vld_o
);
    logic             match_vld, off_vld, free_vld, rel_vld, held_vld;
    logic [IDX_W-1:0] match_idx, off_idx, free_idx, rel_idx, held_idx;
    logic [AGE_W-1:0] rel_age, held_age;
`ifdef SUSTAIN_PEDAL_EN
    logic             sus_vld;
    logic [IDX_W-1:0] sus_idx;
    logic [AGE_W-1:0] sus_age;
`endif

    // One pass over the voices keeps the best candidate of every priority class;
    // strict '>' on age and first-hit flags make ties resolve to the lowest index
    always_comb begin
        match_vld = 1'b0; match_idx = '0;
        off_vld   = 1'b0; off_idx   = '0;
        free_vld  = 1'b0; free_idx  = '0;
        rel_vld   = 1'b0; rel_idx   = '0; rel_age  = '0;
        held_vld  = 1'b0; held_idx  = '0; held_age = '0;
`ifdef SUSTAIN_PEDAL_EN
        sus_vld   = 1'b0; sus_idx   = '0; sus_age  = '0;
`endif
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (note_i[i] == ev_i.note && oct_i[i] == ev_i.octave) begin
                if (state_i[i] != V_FREE && !match_vld) begin
                    match_vld = 1'b1;
                    match_idx = IDX_W'(i);
                end
                if (state_i[i] == V_HELD && !off_vld) begin
                    off_vld = 1'b1;
                    off_idx = IDX_W'(i);
                end
            end
            if (state_i[i] == V_FREE && !free_vld) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (state_i[i] == V_RELEASING && (!rel_vld || age_i[i] > rel_age)) begin
                rel_vld = 1'b1;
                rel_idx = IDX_W'(i);
                rel_age = age_i[i];
            end
            if (state_i[i] == V_HELD && (!held_vld || age_i[i] > held_age)) begin
                held_vld = 1'b1;
                held_idx = IDX_W'(i);
                held_age = age_i[i];
            end
`ifdef SUSTAIN_PEDAL_EN
            if (state_i[i] == V_SUSTAINED && (!sus_vld || age_i[i] > sus_age)) begin
                sus_vld = 1'b1;
                sus_idx = IDX_W'(i);
                sus_age = age_i[i];
            end
`endif
        end
    end

    // Resolve the class priority; out-of-range notes select nothing
    always_comb begin
        sel_vld_o = 1'b0;
        sel_idx_o = '0;
        if (ev_i.note <= MAX_NOTE) begin
            if (ev_i.on) begin
                if (match_vld) begin
                    sel_vld_o = 1'b1; sel_idx_o = match_idx;
                end else if (free_vld) begin
                    sel_vld_o = 1'b1; sel_idx_o = free_idx;
                end else if (rel_vld) begin
                    sel_vld_o = 1'b1; sel_idx_o = rel_idx;
`ifdef SUSTAIN_PEDAL_EN
                end else if (sus_vld) begin
                    sel_vld_o = 1'b1; sel_idx_o = sus_idx;
`endif
                end else if (held_vld) begin
                    sel_vld_o = 1'b1; sel_idx_o = held_idx;
                end
            end else if (off_vld) begin
                sel_vld_o = 1'b1; sel_idx_o = off_idx;
            end
        end
    end
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: maps note events onto NUM_VOICES voices, stealing the oldest.
// Latency: accept at T, voice_note_in pulse at T+2, voice outputs updated at T+3.
// Backpressure: ev_ready high only in IDLE (1 event / 3 cycles). Macro: SUSTAIN_PEDAL_EN.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [OCT_W-1:0]             ev_octave,
`ifdef SUSTAIN_PEDAL_EN
    input  logic                         sustain_pedal,
`endif
    input  logic [NUM_VOICES-1:0]        voice_rel_done,
    output logic [NUM_VOICES-1:0]        voice_note_in,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
    output logic [OCT_W*NUM_VOICES-1:0]  voice_octave,
    output logic [3:0]                   active_count
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    fsm_state_e state_q, state_d;
    event_t     ev_q;
    logic [IDX_W-1:0] sel_idx_q, sel_idx_c;
    logic             sel_vld_q, sel_vld_c;

    voice_state_e [NUM_VOICES-1:0]             vst_q, vst_d;
    logic         [NUM_VOICES-1:0][NOTE_W-1:0] note_q, note_d;
    logic         [NUM_VOICES-1:0][OCT_W-1:0]  oct_q, oct_d;
    logic         [NUM_VOICES-1:0][AGE_W-1:0]  age_q, age_d;
    logic         [3:0]                        active_q, active_d;
`ifdef SUSTAIN_PEDAL_EN
    logic pedal_q;
`endif

    voice_select #(.NUM_VOICES(NUM_VOICES), .AGE_W(AGE_W)) u_select (
        .state_i   (vst_q),
        .note_i    (note_q),
        .oct_i     (oct_q),
        .age_i     (age_q),
        .ev_i      (ev_q),
        .sel_idx_o (sel_idx_c),
        .sel_vld_o (sel_vld_c)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: fixed three-step walk once an event is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (ev_valid) state_d = S_SEARCH;
            S_SEARCH: state_d = S_ASSIGN;
            S_ASSIGN: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: ready in IDLE, load pulse for a committed note-on in ASSIGN
    always_comb begin
        ev_ready      = (state_q == S_IDLE);
        voice_note_in = '0;
        if (state_q == S_ASSIGN && sel_vld_q && ev_q.on) voice_note_in[sel_idx_q] = 1'b1;
    end

    // Latch the accepted event, then register the picker result in SEARCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ev_q      <= '0;
            sel_idx_q <= '0;
            sel_vld_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && ev_valid) ev_q <= '{on: ev_on, note: ev_note, octave: ev_octave};
            if (state_q == S_SEARCH) begin
                sel_idx_q <= sel_idx_c;
                sel_vld_q <= sel_vld_c;
            end
        end
    end

    // Voice next state: release completion first, ASSIGN applied last so it wins
    always_comb begin
        vst_d    = vst_q;
        note_d   = note_q;
        oct_d    = oct_q;
        age_d    = age_q;
        active_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_rel_done[i] && vst_q[i] == V_RELEASING) vst_d[i] = V_FREE;
`ifdef SUSTAIN_PEDAL_EN
            if (pedal_q && !sustain_pedal && vst_q[i] == V_SUSTAINED) vst_d[i] = V_RELEASING;
`endif
        end
        if (state_q == S_ASSIGN && sel_vld_q) begin
            if (ev_q.on) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (vst_q[i] != V_FREE && age_q[i] != AGE_MAX) age_d[i] = age_q[i] + AGE_W'(1);
                end
                vst_d[sel_idx_q]  = V_HELD;
                note_d[sel_idx_q] = ev_q.note;
                oct_d[sel_idx_q]  = ev_q.octave;
                age_d[sel_idx_q]  = '0;
            end else begin
`ifdef SUSTAIN_PEDAL_EN
                vst_d[sel_idx_q] = sustain_pedal ? V_SUSTAINED : V_RELEASING;
`else
                vst_d[sel_idx_q] = V_RELEASING;
`endif
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (vst_d[i] != V_FREE) active_d = active_d + 4'd1;
        end
    end

    // Per-voice registers and the registered occupancy count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_VOICES; i++) vst_q[i] <= V_FREE;
            note_q   <= '0;
            oct_q    <= '0;
            age_q    <= '0;
            active_q <= '0;
`ifdef SUSTAIN_PEDAL_EN
            pedal_q  <= 1'b0;
`endif
        end else begin
            vst_q    <= vst_d;
            note_q   <= note_d;
            oct_q    <= oct_d;
            age_q    <= age_d;
            active_q <= active_d;
`ifdef SUSTAIN_PEDAL_EN
            pedal_q  <= sustain_pedal;
`endif
        end
    end

    // Gate is open while the key (or the pedal) holds the note
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
`ifdef SUSTAIN_PEDAL_EN
            voice_gate[i] = (vst_q[i] == V_HELD) || (vst_q[i] == V_SUSTAINED);
`else
            voice_gate[i] = (vst_q[i] == V_HELD);
`endif
        end
    end

    assign voice_note   = note_q;
    assign voice_octave = oct_q;
    assign active_count = active_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: scoreboard of expected note_in pulses per event.
// Drives on post-edge+1, samples on post-edge+1.
// Every comparison is an immediate assertion that counts and reports its failure.
module tb_voice_allocator;
    localparam int NV = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            ev_valid, ev_ready, ev_on;
    logic [3:0]      ev_note;
    logic [2:0]      ev_octave;
    logic [NV-1:0]   voice_rel_done, voice_note_in, voice_gate;
    logic [4*NV-1:0] voice_note;
    logic [3*NV-1:0] voice_octave;
    logic [3:0]      active_count;

    int checks = 0;
    int errors = 0;
    logic [NV-1:0] exp_q[$];

    always #5 clk = ~clk;

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_on          (ev_on),
        .ev_note        (ev_note),
        .ev_octave      (ev_octave),
        .voice_rel_done (voice_rel_done),
        .voice_note_in  (voice_note_in),
        .voice_gate     (voice_gate),
        .voice_note     (voice_note),
        .voice_octave   (voice_octave),
        .active_count   (active_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [NV-1:0] g, input logic [3:0] a);
        chk({tag, "_gate"}, 32'(voice_gate), 32'(g));
        chk({tag, "_active"}, 32'(active_count), 32'(a));
    endtask

    // Drive one event through the 3-cycle pipeline; rd is applied during ASSIGN
    task automatic send(input string tag, input bit on, input logic [3:0] n, input logic [2:0] o,
                        input int exp_idx, input logic [NV-1:0] rd);
        int            waited;
        logic [NV-1:0] e;
        logic [NV-1:0] got_exp;
        waited = 0;
        e = '0;
        if (exp_idx >= 0) e[exp_idx] = 1'b1;
        ev_valid = 1'b1; ev_on = on; ev_note = n; ev_octave = o;
        while (ev_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk({tag, "_accept"}, 32'(waited < 20), 32'd1);
        exp_q.push_back(e);
        @(posedge clk); #1;
        ev_valid = 1'b0;
        chk({tag, "_rdy_search"}, 32'(ev_ready), 32'd0);
        chk({tag, "_no_early_pulse"}, 32'(voice_note_in), 32'd0);
        @(posedge clk); #1;
        voice_rel_done = rd;
        chk({tag, "_rdy_assign"}, 32'(ev_ready), 32'd0);
        got_exp = exp_q.pop_front();
        chk({tag, "_note_in"}, 32'(voice_note_in), 32'(got_exp));
        @(posedge clk); #1;
        voice_rel_done = '0;
        chk({tag, "_rdy_back"}, 32'(ev_ready), 32'd1);
    endtask

    task automatic rel(input logic [NV-1:0] rd);
        voice_rel_done = rd;
        @(posedge clk); #1;
        voice_rel_done = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_octave = '0;
        voice_rel_done = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_ready", 32'(ev_ready), 32'd1);
        chk("rst_note_in", 32'(voice_note_in), 32'd0);
        chk_state("rst", 4'b0000, 4'd0);
        chk("rst_note", 32'(voice_note), 32'd0);
        chk("rst_oct", 32'(voice_octave), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // First note-on lands on voice 0
        send("c4", 1'b1, 4'd0, 3'd4, 0, '0);
        chk_state("c4", 4'b0001, 4'd1);
        chk("c4_oct", 32'(voice_octave), 32'h004);

        // Fill all voices, then steal the oldest held one (voice 0)
        send("d4", 1'b1, 4'd2, 3'd4, 1, '0);
        send("e4", 1'b1, 4'd4, 3'd4, 2, '0);
        send("f4", 1'b1, 4'd5, 3'd4, 3, '0);
        chk_state("full", 4'b1111, 4'd4);
        chk("full_note", 32'(voice_note), 32'h5420);
        send("steal", 1'b1, 4'd7, 3'd4, 0, '0);
        chk_state("steal", 4'b1111, 4'd4);
        chk("steal_note", 32'(voice_note), 32'h5427);

        // Note-on 9 steals voice 1; note-off releases it; rel_done frees it
        send("a4_on", 1'b1, 4'd9, 3'd4, 1, '0);
        chk("a4_note", 32'(voice_note), 32'h5497);
        send("a4_off", 1'b0, 4'd9, 3'd4, -1, '0);
        chk_state("a4_off", 4'b1101, 4'd4);
        rel(4'b0011);
        chk_state("a4_free", 4'b1101, 4'd3);
        send("a4_off2", 1'b0, 4'd9, 3'd4, -1, '0);
        chk_state("a4_off2", 4'b1101, 4'd3);

        // Retrigger a releasing voice even though a free voice exists
        send("e3_on", 1'b1, 4'd4, 3'd3, 1, '0);
        chk_state("e3_on", 4'b1111, 4'd4);
        chk("e3_oct", 32'(voice_octave), 32'h91C);
        send("e3_off", 1'b0, 4'd4, 3'd3, -1, '0);
        send("f4_off", 1'b0, 4'd5, 3'd4, -1, '0);
        chk_state("two_rel", 4'b0101, 4'd4);
        rel(4'b1000);
        chk_state("v3_free", 4'b0101, 4'd3);
        send("e3_retrig", 1'b1, 4'd4, 3'd3, 1, '0);
        chk_state("e3_retrig", 4'b0111, 4'd3);

        // rel_done collides with ASSIGN on voice 0: voice stays HELD
        send("g4_off", 1'b0, 4'd7, 3'd4, -1, '0);
        chk_state("g4_off", 4'b0110, 4'd3);
        send("g4_collide", 1'b1, 4'd7, 3'd4, 0, 4'b0001);
        chk_state("g4_collide", 4'b0111, 4'd3);

        // Out-of-range note is accepted and dropped
        send("bad_note", 1'b1, 4'd13, 3'd4, -1, '0);
        chk_state("bad_note", 4'b0111, 4'd3);
        chk("bad_note_note", 32'(voice_note), 32'h5447);
        chk("bad_note_oct", 32'(voice_octave), 32'h91C);

        // Oldest releasing voice is reused before any held voice is stolen
        send("b4_on", 1'b1, 4'd11, 3'd4, 3, '0);
        chk_state("b4_on", 4'b1111, 4'd4);
        send("e3_off_b", 1'b0, 4'd4, 3'd3, -1, '0);
        send("g4_off_b", 1'b0, 4'd7, 3'd4, -1, '0);
        chk_state("rel_pair", 4'b1100, 4'd4);
        send("cs4_on", 1'b1, 4'd1, 3'd4, 1, '0);
        chk_state("cs4_on", 4'b1110, 4'd4);

        // Reset in the middle of SEARCH discards the event immediately
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 4'd2; ev_octave = 3'd4;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        chk("mid_rdy_search", 32'(ev_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk_state("mid_rst", 4'b0000, 4'd0);
        chk("mid_rst_note", 32'(voice_note), 32'd0);
        chk("mid_rst_oct", 32'(voice_octave), 32'd0);
        chk("mid_rst_note_in", 32'(voice_note_in), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_rdy", 32'(ev_ready), 32'd1);
        chk("mid_rel_note_in", 32'(voice_note_in), 32'd0);
        @(posedge clk); #1;
        chk("mid_rel_note_in2", 32'(voice_note_in), 32'd0);
        chk_state("mid_rel", 4'b0000, 4'd0);

        // Allocator is fully usable again
        send("after_rst", 1'b1, 4'd3, 3'd2, 0, '0);
        chk_state("after_rst", 4'b0001, 4'd1);
        chk("after_rst_note", 32'(voice_note), 32'h0003);
        chk("after_rst_oct", 32'(voice_octave), 32'h002);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
